// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing, EX operand forwarding select, event counters.
// Define HAZARD_FORWARDING_EN to enable forwarding (load-use stalls only).
module pipeline_hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_rd,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic        mem_redirect,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        ex_mem_flush,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_events
);

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 2;
   localparam int unsigned CNT_W = 16;

   localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
   localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [REG_W-1:0]   ex_rs_q, ex_rt_q;
   logic [REG_W-1:0]   ex_rs_d, ex_rt_d;
   logic               pc_write_d, if_id_write_d, if_id_flush_d;
   logic               id_ex_bubble_d, ex_mem_flush_d;
   logic [FWD_W-1:0]   fwd_a_d, fwd_b_d;
   logic               stall_inc, flush_inc;
   logic               hazard_c;

   // Register 0 is hardwired to zero and can never create a dependence.
   function automatic logic src_match(input logic [REG_W-1:0] src,
                                      input logic             wr,
                                      input logic [REG_W-1:0] dst);
      return (src != '0) && wr && (src == dst);
   endfunction

`ifdef HAZARD_FORWARDING_EN
   function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src);
      if (src_match(src, mem_reg_write, mem_rd))
         return FWD_EXMEM;
      else if (src_match(src, wb_reg_write, wb_rd))
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

   // Only a load in EX cannot be forwarded in time.
   always_comb begin
      hazard_c = src_match(id_rs, ex_reg_write && ex_mem_read, ex_rd) ||
                 (id_uses_rt && src_match(id_rt, ex_reg_write && ex_mem_read, ex_rd));
      fwd_a_d  = fwd_sel(ex_rs_q);
      fwd_b_d  = fwd_sel(ex_rt_q);
   end
`else
   function automatic logic dep_any(input logic [REG_W-1:0] src);
      return src_match(src, ex_reg_write,  ex_rd)  ||
             src_match(src, mem_reg_write, mem_rd) ||
             src_match(src, wb_reg_write,  wb_rd);
   endfunction

   // Without forwarding the consumer waits until the producer has retired.
   always_comb begin
      hazard_c = dep_any(id_rs) || (id_uses_rt && dep_any(id_rt));
      fwd_a_d  = FWD_RF;
      fwd_b_d  = FWD_RF;
   end

   logic unused_ok;
   assign unused_ok = ^{ex_mem_read, ex_rs_q, ex_rt_q};
`endif

   // Next-state and next-output decode; redirect outranks any hazard.
   always_comb begin
      state_d        = state_q;
      pc_write_d     = 1'b1;
      if_id_write_d  = 1'b1;
      if_id_flush_d  = 1'b0;
      id_ex_bubble_d = 1'b0;
      ex_mem_flush_d = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
      ex_rs_d        = id_rs;
      ex_rt_d        = id_rt;

      case (state_q)
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            if (mem_redirect) begin
               state_d        = ST_FLUSH;
               if_id_flush_d  = 1'b1;
               id_ex_bubble_d = 1'b1;
               ex_mem_flush_d = 1'b1;
               flush_inc      = 1'b1;
            end else if (hazard_c) begin
               state_d        = ST_STALL;
               pc_write_d     = 1'b0;
               if_id_write_d  = 1'b0;
               id_ex_bubble_d = 1'b1;
               stall_inc      = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
      endcase

      if (id_ex_bubble_d) begin
         ex_rs_d = '0;
         ex_rt_d = '0;
      end
   end

   // State, registered controls, shadows and saturating counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         pc_write     <= 1'b0;
         if_id_write  <= 1'b0;
         if_id_flush  <= 1'b1;
         id_ex_bubble <= 1'b1;
         ex_mem_flush <= 1'b1;
         fwd_a        <= FWD_RF;
         fwd_b        <= FWD_RF;
         ex_rs_q      <= '0;
         ex_rt_q      <= '0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state_q      <= state_d;
         pc_write     <= pc_write_d;
         if_id_write  <= if_id_write_d;
         if_id_flush  <= if_id_flush_d;
         id_ex_bubble <= id_ex_bubble_d;
         ex_mem_flush <= ex_mem_flush_d;
         fwd_a        <= fwd_a_d;
         fwd_b        <= fwd_b_d;
         ex_rs_q      <= ex_rs_d;
         ex_rt_q      <= ex_rt_d;
         if (stall_inc && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_inc && (flush_events != CNT_MAX))
            flush_events <= flush_events + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  async active-low reset
- id_rs  in  5  rs of instruction in ID
- id_rt  in  5  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_reg_write  in  1  EX instruction writes a register
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- mem_reg_write  in  1  MEM instruction writes a register
- mem_rd  in  5  MEM destination register
- wb_reg_write  in  1  WB instruction writes a register
- wb_rd  in  5  WB destination register
- mem_redirect  in  1  taken branch or jump resolved in MEM
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may load
- if_id_flush  out  1  squash IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_mem_flush  out  1  squash EX/MEM
- fwd_a  out  2  ALU op1 source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data
- fwd_b  out  2  ALU op2 source, same encoding
- stall_cycles  out  16  saturating stall-cycle count
- flush_events  out  16  saturating redirect count

Function
REQ-003 FSM states SHALL be RUN, STALL, FLUSH; encoding is free.
REQ-004 Hazard SHALL be defined as: source register (rs; rt only if id_uses_rt) nonzero and equal to a qualifying destination; register 0 never hazards.
REQ-005 In RUN with no hazard and no redirect, outputs SHALL be pc_write=1, if_id_write=1, all flush/bubble=0.
REQ-006 On hazard (and no redirect), next state SHALL be STALL; while in STALL with hazard present: pc_write=0, if_id_write=0, id_ex_bubble=1; return to RUN on the first cycle the hazard clears.
REQ-007 mem_redirect SHALL take priority over any hazard: in that cycle if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1; next state FLUSH.
REQ-008 FLUSH SHALL last exactly one cycle with RUN outputs, then evaluate hazards normally; a new mem_redirect in FLUSH SHALL be ignored (squashed slot).
REQ-009 The block SHALL hold internal ex_rs/ex_rt shadow registers loaded from id_rs/id_rt when ID advances, cleared to 0 on bubble or flush.
REQ-010 stall_cycles SHALL increment each cycle id_ex_bubble=1 due to hazard; flush_events SHALL increment on each accepted mem_redirect; both saturate at 16'hFFFF.

Reset
REQ-011 While rst_n=0: state RUN, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, fwd_a=fwd_b=00, counters 0, shadows 0.
REQ-012 Reset asserted mid-STALL or mid-FLUSH SHALL abort immediately; first cycle after release is RUN.

Configuration
REQ-013 Macro HAZARD_FORWARDING_EN SHALL select forwarding.
REQ-014 Defined: hazard qualifies only against EX with ex_reg_write=1 and ex_mem_read=1 (load-use, 1-cycle stall); fwd_a/fwd_b driven from ex_rs/ex_rt, EX/MEM match (mem_reg_write, mem_rd!=0) over MEM/WB match.
REQ-015 Undefined: hazard qualifies against any of EX, MEM, WB with the corresponding reg_write=1 (up to 3 stall cycles); fwd_a=fwd_b=00 constant.

Verification
REQ-016 Scenarios:
- Forwarding on: load to r8 in EX, ID reads rs=8 -> exactly 1 stall cycle, then fwd_a=10 next EX cycle.
- Forwarding on: add r9 in MEM, EX rt=9, id_uses_rt -> fwd_b=01, no stall.
- Forwarding off: ex_rd=5 write, ID rs=5 -> 3 stall cycles as r5 moves EX/MEM/WB, stall_cycles=3.
- Hazard and mem_redirect same cycle -> all three flushes=1, pc_write=1, stall_cycles unchanged, flush_events+1.
- rs=0, ex_rd=0, ex_reg_write=1 -> no stall.
- rst_n low during STALL -> outputs at reset values asynchronously; RUN after release; counters 0.
